accelbrot_com_mult_arb: RTL and testbench

Round-robin arbiter that shares one word-serial multiplier unit (`accelbrot_com_mult_unx1`, same `NWORDS`/`WWIDTH`) between `NREQ` requesters. Each grant covers exactly one block of `NWORDS` contiguous words, so the multiplier's inter-word carry is never interleaved between owners. A delay line of owner tags routes returning result words to the requester that issued them. It sits between the iteration engines and the shared multiplier.

---
 rtl/accelbrot_com_mult_arb.sv | 173 +++++++++++++++++
 tb/tb_accelbrot_com_mult_arb.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accelbrot_com_mult_arb.sv
// Round-robin arbiter that shares one word-serial multiplier between NREQ requesters.
// Grants whole NWORDS blocks; a tag delay line routes returning words to their issuer.
module accelbrot_com_mult_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned NWORDS  = 8,
    parameter int unsigned WWIDTH  = 34,
    parameter int unsigned LATENCY = 3,
    localparam int unsigned HWIDTH = WWIDTH / 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ*WWIDTH-1:0]   req_a,
    input  logic [NREQ*HWIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]          req_start,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    output logic [WWIDTH-1:0]        m_a,
    output logic [HWIDTH-1:0]        m_b,
    output logic                     m_start,
    output logic                     m_valid,
    input  logic [WWIDTH-1:0]        m_q,
    input  logic                     m_q_start,
    input  logic                     m_q_valid,
    output logic [WWIDTH-1:0]        rsp_q,
    output logic                     rsp_start,
    output logic [NREQ-1:0]          rsp_valid,
    output logic                     err
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);
    localparam logic [CW-1:0] LastCnt = CW'(NWORDS - 1);

    typedef enum logic {StIdle, StBurst} state_t;

    state_t              r_state;
    logic [GW-1:0]       r_gnt;
    logic [GW-1:0]       r_ptr;
    logic [CW-1:0]       r_cnt;
    logic                r_err;
    logic [NREQ-1:0]     r_ready;
    logic [WWIDTH-1:0]   r_m_a;
    logic [HWIDTH-1:0]   r_m_b;
    logic                r_m_start;
    logic                r_m_valid;
    logic [GW-1:0]       r_m_own;
    logic                r_tag_v [LATENCY];
    logic [GW-1:0]       r_tag_o [LATENCY];

    logic [WWIDTH-1:0]   w_a_arr [NREQ];
    logic [HWIDTH-1:0]   w_b_arr [NREQ];
    logic [NREQ-1:0]     w_cand;
    logic                w_found;
    logic [GW-1:0]       w_pick;
    logic [GW-1:0]       w_idx;
    logic                w_req_v;
    logic                w_req_s;
    logic                w_tag_hit;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            w_a_arr[i] = req_a[i*WWIDTH +: WWIDTH];
            w_b_arr[i] = req_b[i*HWIDTH +: HWIDTH];
        end
    end

    assign w_cand  = req_valid & req_start;
    assign w_req_v = req_valid[r_gnt];
    assign w_req_s = req_start[r_gnt];

    // Search starts just after the last owner, so it wraps round to ptr itself last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            w_idx = GW'((int'(r_ptr) + k) % int'(NREQ));
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= StIdle;
            r_gnt     <= '0;
            r_ptr     <= GW'(NREQ - 1);
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_ready   <= '0;
            r_m_a     <= '0;
            r_m_b     <= '0;
            r_m_start <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_own   <= '0;
        end else begin
            // Idle cycles drive zeros so the multiplier carry stays clear between blocks.
            r_m_a     <= '0;
            r_m_b     <= '0;
            r_m_start <= 1'b0;
            r_m_valid <= 1'b0;
            if (m_q_valid && !r_tag_v[LATENCY-1]) begin
                r_err <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_state <= StBurst;
                        r_gnt   <= w_pick;
                        r_ptr   <= w_pick;
                        r_cnt   <= '0;
                        r_ready <= OneHot0 << w_pick;
                    end
                end
                StBurst: begin
                    if (!w_req_v) begin
                        r_state <= StIdle;
                        r_err   <= 1'b1;
                        r_ready <= '0;
                    end else begin
                        r_m_a     <= w_a_arr[r_gnt];
                        r_m_b     <= w_b_arr[r_gnt];
                        r_m_start <= (r_cnt == '0);
                        r_m_valid <= 1'b1;
                        r_m_own   <= r_gnt;
                        if (w_req_s && (r_cnt != '0)) begin
                            r_err <= 1'b1;
                        end
                        if (r_cnt == LastCnt) begin
                            r_state <= StIdle;
                            r_ready <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_tag_v[i] <= 1'b0;
                r_tag_o[i] <= '0;
            end
        end else begin
            r_tag_v[0] <= r_m_valid;
            r_tag_o[0] <= r_m_own;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_o[i] <= r_tag_o[i-1];
            end
        end
    end

    assign w_tag_hit = m_q_valid & r_tag_v[LATENCY-1];

    assign req_ready = r_ready;
    assign m_a       = r_m_a;
    assign m_b       = r_m_b;
    assign m_start   = r_m_start;
    assign m_valid   = r_m_valid;
    assign rsp_q     = m_q;
    assign rsp_start = m_q_start;
    assign rsp_valid = w_tag_hit ? (OneHot0 << r_tag_o[LATENCY-1]) : '0;
    assign err       = r_err;

endmodule

// File: tb/tb_accelbrot_com_mult_arb.sv
// Scoreboard bench for accelbrot_com_mult_arb with a behavioural word-serial multiplier.
// Drivers push expected result words on acceptance; a negedge monitor pops and compares.
module tb_accelbrot_com_mult_arb;

    localparam int NR  = 4;
    localparam int NW  = 8;
    localparam int WW  = 34;
    localparam int HW  = 17;
    localparam int LAT = 3;

    typedef struct {
        int          owner;
        logic [WW-1:0] q;
        logic        start;
        int          due;
    } exp_t;

    logic              clk;
    logic              rstn;
    logic [NR*WW-1:0]  req_a;
    logic [NR*HW-1:0]  req_b;
    logic [NR-1:0]     req_start;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [WW-1:0]     m_a;
    logic [HW-1:0]     m_b;
    logic              m_start;
    logic              m_valid;
    logic [WW-1:0]     m_q;
    logic              m_q_start;
    logic              m_q_valid;
    logic [WW-1:0]     rsp_q;
    logic              rsp_start;
    logic [NR-1:0]     rsp_valid;
    logic              err;

    logic [WW-1:0] a_r [NR];
    logic [HW-1:0] b_r [NR];
    logic          s_r [NR];
    logic          v_r [NR];

    int   cyc;
    int   n_checks;
    int   n_errors;
    int   n_mv;
    int   n_ms;
    exp_t sb [$];
    int   grant_log [$];
    int   start_cyc [$];

    accelbrot_com_mult_arb #(
        .NREQ    (NR),
        .NWORDS  (NW),
        .WWIDTH  (WW),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_start (req_start),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .m_a       (m_a),
        .m_b       (m_b),
        .m_start   (m_start),
        .m_valid   (m_valid),
        .m_q       (m_q),
        .m_q_start (m_q_start),
        .m_q_valid (m_q_valid),
        .rsp_q     (rsp_q),
        .rsp_start (rsp_start),
        .rsp_valid (rsp_valid),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_a     = '0;
        req_b     = '0;
        req_start = '0;
        req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            req_a[i*WW +: WW] = a_r[i];
            req_b[i*HW +: HW] = b_r[i];
            req_start[i]      = s_r[i];
            req_valid[i]      = v_r[i];
        end
    end

    // Behavioural multiplier: A word times held B plus running carry, LAT-stage pipeline.
    logic [HW-1:0] st_b;
    logic [HW-1:0] st_c;
    logic [HW-1:0] s_b;
    logic [HW-1:0] s_cin;
    logic [63:0]   s_prod;
    logic [WW-1:0] pq [LAT];
    logic          ps [LAT];
    logic          pv [LAT];

    always_comb begin
        s_b    = m_start ? m_b : st_b;
        s_cin  = m_start ? '0 : st_c;
        s_prod = 64'(m_a) * 64'(s_b) + 64'(s_cin);
    end

    always @(posedge clk) begin
        if (!rstn) begin
            st_b <= '0;
            st_c <= '0;
            for (int i = 0; i < LAT; i++) begin
                pq[i] <= '0;
                ps[i] <= 1'b0;
                pv[i] <= 1'b0;
            end
        end else begin
            if (m_valid) begin
                st_b <= s_b;
                st_c <= HW'(s_prod >> WW);
            end
            pq[0] <= m_valid ? WW'(s_prod) : '0;
            ps[0] <= m_valid & m_start;
            pv[0] <= m_valid;
            for (int i = 1; i < LAT; i++) begin
                pq[i] <= pq[i-1];
                ps[i] <= ps[i-1];
                pv[i] <= pv[i-1];
            end
        end
    end

    assign m_q       = pq[LAT-1];
    assign m_q_start = ps[LAT-1];
    assign m_q_valid = pv[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every routed result word must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_valid) n_mv++;
            if (m_start) begin
                n_ms++;
                start_cyc.push_back(cyc);
            end
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", 64'(rsp_valid), 64'(4'b0001 << e.owner));
                    chk("rsp_q", 64'(rsp_q), 64'(e.q));
                    chk("rsp_start", 64'(rsp_start), 64'(e.start));
                    chk("rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    // mode 0: result = a*b; mode 1: all-ones operand chain with propagated carries.
    task automatic send_block(input int r, input logic [WW-1:0] w0, input logic [WW-1:0] step,
                              input logic [HW-1:0] b, input int drop_at, input int start_at,
                              input int rst_at, input int mode, output int first_acc,
                              output int last_acc);
        int k;
        int wait_n;
        logic [WW-1:0] w;
        exp_t e;
        k = 0;
        wait_n = 0;
        first_acc = -1;
        last_acc = -1;
        w = w0;
        a_r[r] = w;
        b_r[r] = b;
        s_r[r] = 1'b1;
        v_r[r] = 1'b1;
        while (k < NW) begin
            @(negedge clk);
            if (k == drop_at && req_ready[r]) begin
                v_r[r] = 1'b0;
                s_r[r] = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            if (k == rst_at && req_ready[r]) begin
                rstn = 1'b0;
                v_r[r] = 1'b0;
                s_r[r] = 1'b0;
                @(posedge clk);
                #1;
                rstn = 1'b1;
                sb.delete();
                return;
            end
            if (req_ready[r]) begin
                @(posedge clk);
                #1;
                if (k == 0) begin
                    first_acc = cyc;
                    grant_log.push_back(r);
                end
                last_acc = cyc;
                e.owner = r;
                if (mode == 1) e.q = (k == 0) ? 34'h3_FFFE_0001 : 34'h3_FFFF_FFFF;
                else e.q = WW'(64'(w) * 64'(b));
                e.start = (k == 0);
                e.due = cyc + LAT;
                sb.push_back(e);
                k++;
                if (k < NW) begin
                    w = w0 + WW'(k) * step;
                    a_r[r] = w;
                    s_r[r] = (k == start_at);
                end else begin
                    v_r[r] = 1'b0;
                    s_r[r] = 1'b0;
                end
                wait_n = 0;
            end else begin
                wait_n++;
                if (wait_n > 200) begin
                    chk("ready_timeout", 64'(r), 64'(-1));
                    v_r[r] = 1'b0;
                    s_r[r] = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic simple(input int r, input int base, input int b);
        int f;
        int l;
        send_block(r, WW'(base), WW'(1), HW'(b), -1, -1, -1, 0, f, l);
    endtask

    task automatic two_blocks(input int r);
        simple(r, 16 * r + 1, r + 1);
        simple(r, 16 * r + 9, r + 1);
    endtask

    task automatic do_reset();
        repeat (LAT + 3) @(posedge clk);
        #1;
        chk("drained", 64'(sb.size()), 64'(0));
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        sb.delete();
        grant_log.delete();
        start_cyc.delete();
        n_mv = 0;
        n_ms = 0;
    endtask

    initial begin
        int f;
        int l;
        int t0;
        rstn = 1'b0;
        for (int i = 0; i < NR; i++) begin
            a_r[i] = '0;
            b_r[i] = '0;
            s_r[i] = 1'b0;
            v_r[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_start", 64'(m_start), 64'(0));
        chk("rst_m_a", 64'(m_a), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_err", 64'(err), 64'(0));

        // Single block from requester 2: a = 1..8, b = 3.
        t0 = cyc;
        send_block(2, WW'(1), WW'(1), HW'(3), -1, -1, -1, 0, f, l);
        chk("single_first_acc", 64'(f), 64'(t0 + 2));
        chk("single_contiguous", 64'(l - f), 64'(NW - 1));
        chk("single_grant", 64'(grant_log[0]), 64'(2));

        // Simultaneous start from requesters 0 and 1.
        do_reset();
        fork
            simple(0, 1, 2);
            simple(1, 11, 5);
        join
        chk("sim_grant0", 64'(grant_log[0]), 64'(0));
        chk("sim_grant1", 64'(grant_log[1]), 64'(1));
        chk("sim_bubble", 64'(start_cyc[1] - start_cyc[0]), 64'(NW + 1));

        // Fairness: all four requesters, two blocks each.
        do_reset();
        fork
            two_blocks(0);
            two_blocks(1);
            two_blocks(2);
            two_blocks(3);
        join
        chk("fair_count", 64'(grant_log.size()), 64'(8));
        for (int i = 0; i < 8; i++) chk("fair_order", 64'(grant_log[i]), 64'(i % 4));
        chk("fair_err", 64'(err), 64'(0));

        // Carry chain, then a fresh block from another requester with carry 0.
        do_reset();
        send_block(3, 34'h3_FFFF_FFFF, WW'(0), 17'h1_FFFF, -1, -1, -1, 1, f, l);
        simple(1, 1, 1);
        chk("carry_err", 64'(err), 64'(0));

        // Requester 1 drops valid at word 4; requester 2 follows.
        do_reset();
        fork
            send_block(1, WW'(1), WW'(1), HW'(7), 4, -1, -1, 0, f, l);
            simple(2, 21, 2);
        join
        chk("drop_grant0", 64'(grant_log[0]), 64'(1));
        chk("drop_grant1", 64'(grant_log[1]), 64'(2));
        chk("drop_err", 64'(err), 64'(1));

        // Spurious start at word 3: still 8 words, one m_start.
        do_reset();
        send_block(0, WW'(1), WW'(1), HW'(2), -1, 3, -1, 0, f, l);
        repeat (LAT + 2) @(posedge clk);
        #1;
        chk("sstart_m_start", 64'(n_ms), 64'(1));
        chk("sstart_m_valid", 64'(n_mv), 64'(NW));
        chk("sstart_err", 64'(err), 64'(1));

        // Reset for one cycle at word 5 of a block.
        do_reset();
        send_block(1, WW'(1), WW'(1), HW'(3), -1, -1, 5, 0, f, l);
        chk("mrst_ready", 64'(req_ready), 64'(0));
        chk("mrst_m_valid", 64'(m_valid), 64'(0));
        chk("mrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mrst_err", 64'(err), 64'(0));
        repeat (LAT + 2) @(posedge clk);
        #1;
        grant_log.delete();
        fork
            simple(3, 31, 1);
            simple(0, 41, 1);
        join
        chk("mrst_grant0", 64'(grant_log[0]), 64'(0));
        chk("mrst_grant1", 64'(grant_log[1]), 64'(3));

        repeat (LAT + 3) @(posedge clk);
        #1;
        chk("final_drained", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
